// File: rtl/bcd_timer_ctrl.sv
// BCD decade-chain run controller: start/stop/clear, target match, done/err pulses.
// Optional BCD_TIMER_AUTORELOAD_EN: restart from zero on each match instead of DONE.
module bcd_timer_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic                  tick,
   input  logic [4*DIGITS-1:0]   target,
   output logic [4*DIGITS-1:0]   count,
   output logic [1:0]            state,
   output logic                  done,
   output logic                  err
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   count_q, count_d;
   logic [W-1:0]   tgt_q, tgt_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [W-1:0]   count_inc;
   logic           tgt_ok;

   // Per-digit increment; a digit at 9 wraps and carries onward.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic bcd_valid(input logic [W-1:0] v);
      logic ok;
      ok = |v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   assign count_inc = bcd_inc(count_q);
   assign tgt_ok    = bcd_valid(target);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tgt_d   = tgt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
         count_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (tgt_ok) begin
                     tgt_d   = target;
                     count_d = '0;
                     state_d = S_RUN;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (stop) begin
                  state_d = S_PAUSE;
               end else if (tick) begin
                  if (count_inc == tgt_q) begin
                     done_d = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
                     count_d = '0;
`else
                     count_d = tgt_q;
                     state_d = S_DONE;
`endif
                  end else begin
                     count_d = count_inc;
                  end
               end
            end
            S_PAUSE: begin
               if (start) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         tgt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tgt_q   <= tgt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign count = count_q;
   assign state = state_q;
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed self-checking bench for bcd_timer_ctrl (DIGITS=4).
// Define BCD_TIMER_AUTORELOAD_EN to exercise the autoreload build.
module tb_bcd_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, stop, clear, tick;
   logic [15:0] target, count;
   logic [1:0]  state;
   logic        done, err;
   int          checks = 0;
   int          errors = 0;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] RUN   = 2'b01;
   localparam logic [1:0] PAUSE = 2'b10;
   localparam logic [1:0] DONE  = 2'b11;

   bcd_timer_ctrl #(.DIGITS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .clear(clear), .tick(tick), .target(target),
      .count(count), .state(state), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
   endfunction

   task automatic idle_in();
      start = 0; stop = 0; clear = 0; tick = 0;
   endtask

   task automatic test_reset();
      rst = 0; idle_in(); target = 16'h0000;
      cyc(); cyc();
      rst = 1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         checks++;
         if ({count, state, done, err} !== {16'h0, IDLE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle cyc%0d count=%h state=%b done=%b err=%b want 0000/00/0/0",
                     i, count, state, done, err);
         end
      end
   endtask

   task automatic test_carry();
      logic [15:0] exp;
      target = 16'h0100; start = 1;
      cyc();
      start = 0;
      checks++;
      if (state !== RUN || count !== 16'h0) begin
         errors++;
         $display("FAIL carry_start state=%b count=%h want 01/0000", state, count);
      end
      tick = 1;
      for (int i = 1; i <= 100; i++) begin
         cyc();
         exp = to_bcd(i);
         checks++;
         if (count !== exp || done !== (i == 100) || state !== ((i == 100) ? DONE : RUN)) begin
            errors++;
            $display("FAIL carry_tick%0d count=%h done=%b state=%b want %h/%b/%b",
                     i, count, done, state, exp, (i == 100), (i == 100) ? DONE : RUN);
         end
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (count !== 16'h0100 || state !== DONE || done !== 1'b0) begin
            errors++;
            $display("FAIL carry_hold count=%h state=%b done=%b want 0100/11/0",
                     count, state, done);
         end
      end
      tick = 0;
   endtask

   task automatic test_restart();
      target = 16'h0005; start = 1;
      cyc();
      start = 0;
      checks++;
      if (state !== RUN || count !== 16'h0 || err !== 1'b0) begin
         errors++;
         $display("FAIL restart state=%b count=%h err=%b want 01/0000/0", state, count, err);
      end
      clear = 1; cyc(); clear = 0;
      checks++;
      if (state !== IDLE || count !== 16'h0) begin
         errors++;
         $display("FAIL clear_run state=%b count=%h want 00/0000", state, count);
      end
   endtask

   task automatic test_pause();
      target = 16'h0020; start = 1; cyc(); start = 0;
      target = 16'h0003;
      tick = 1;
      repeat (7) cyc();
      stop = 1; cyc(); stop = 0;
      checks++;
      if (count !== 16'h0007 || state !== PAUSE) begin
         errors++;
         $display("FAIL pause_stop count=%h state=%b want 0007/10", count, state);
      end
      repeat (5) cyc();
      checks++;
      if (count !== 16'h0007 || state !== PAUSE) begin
         errors++;
         $display("FAIL pause_ticks count=%h state=%b want 0007/10", count, state);
      end
      start = 1; cyc(); start = 0;
      checks++;
      if (count !== 16'h0007 || state !== RUN) begin
         errors++;
         $display("FAIL resume count=%h state=%b want 0007/01", count, state);
      end
      for (int i = 1; i <= 13; i++) begin
         cyc();
         checks++;
         if (done !== (i == 13) || count !== to_bcd(7 + i)) begin
            errors++;
            $display("FAIL resume_tick%0d count=%h done=%b want %h/%b",
                     i, count, done, to_bcd(7 + i), (i == 13));
         end
      end
      tick = 0;
      checks++;
      if (state !== DONE) begin
         errors++;
         $display("FAIL pause_done state=%b want 11", state);
      end
      clear = 1; cyc(); clear = 0;
   endtask

   task automatic test_reject();
      target = 16'h00A3; start = 1; cyc(); start = 0;
      checks++;
      if (err !== 1'b1 || state !== IDLE) begin
         errors++;
         $display("FAIL rej_digit err=%b state=%b want 1/00", err, state);
      end
      cyc();
      checks++;
      if (err !== 1'b0 || state !== IDLE) begin
         errors++;
         $display("FAIL rej_pulse err=%b state=%b want 0/00", err, state);
      end
      target = 16'h0000; start = 1; cyc(); start = 0;
      checks++;
      if (err !== 1'b1 || state !== IDLE) begin
         errors++;
         $display("FAIL rej_zero err=%b state=%b want 1/00", err, state);
      end
      target = 16'h0003; start = 1; cyc(); start = 0;
      checks++;
      if (err !== 1'b0 || state !== RUN || count !== 16'h0) begin
         errors++;
         $display("FAIL accept err=%b state=%b count=%h want 0/01/0000", err, state, count);
      end
   endtask

   task automatic test_clear_prio();
      tick = 1; cyc(); cyc(); tick = 0;
      checks++;
      if (count !== 16'h0002 || state !== RUN) begin
         errors++;
         $display("FAIL clr_pre count=%h state=%b want 0002/01", count, state);
      end
      clear = 1; tick = 1; cyc(); clear = 0; tick = 0;
      checks++;
      if (count !== 16'h0 || state !== IDLE || done !== 1'b0) begin
         errors++;
         $display("FAIL clr_prio count=%h state=%b done=%b want 0000/00/0",
                  count, state, done);
      end
   endtask

   task automatic test_reset_mid();
      target = 16'h0004; start = 1; cyc(); start = 0;
      tick = 1; cyc(); cyc(); cyc();
      rst = 0; cyc(); rst = 1;
      checks++;
      if (count !== 16'h0 || state !== IDLE || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid count=%h state=%b done=%b want 0000/00/0",
                  count, state, done);
      end
      cyc(); tick = 0;
      checks++;
      if (count !== 16'h0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_idle count=%h done=%b want 0000/0", count, done);
      end
   endtask

`ifdef BCD_TIMER_AUTORELOAD_EN
   task automatic test_autoreload();
      logic exp_d;
      target = 16'h0003; start = 1; cyc(); start = 0;
      tick = 1;
      for (int i = 1; i <= 9; i++) begin
         cyc();
         exp_d = (i % 3 == 0);
         checks++;
         if (done !== exp_d || state !== RUN || count !== to_bcd(i % 3)) begin
            errors++;
            $display("FAIL autoreload_tick%0d done=%b state=%b count=%h want %b/01/%h",
                     i, done, state, count, exp_d, to_bcd(i % 3));
         end
      end
      tick = 0;
      clear = 1; cyc(); clear = 0;
   endtask
`endif

   initial begin
      test_reset();
`ifdef BCD_TIMER_AUTORELOAD_EN
      test_autoreload();
`else
      test_carry();
      test_restart();
      test_pause();
`endif
      test_reject();
      test_clear_prio();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
